// File: rtl/otter_pkg.sv
// rtl/otter_pkg.sv - shared OTTER opcode, func3, pc_sel and branch-resolve state definitions
package otter_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        PC_SEL_PC4    = 2'd0,
        PC_SEL_JALR   = 2'd1,
        PC_SEL_BRANCH = 2'd2,
        PC_SEL_JAL    = 2'd3
    } pc_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_FLUSH    = 2'd2
    } br_state_e;

endpackage

// File: rtl/br_taken_decode.sv
// rtl/br_taken_decode.sv - combinational opcode/func3/flag decode into taken, pc_sel and illegal
module br_taken_decode
    import otter_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] func3_i,
    input  logic       br_eq_i,
    input  logic       br_lt_i,
    input  logic       br_ltu_i,
    output logic       taken_o,
    output pc_sel_e    sel_o,
    output logic       illegal_o,
    output logic       is_branch_o
);

    always_comb begin
        taken_o     = 1'b0;
        sel_o       = PC_SEL_PC4;
        illegal_o   = 1'b0;
        is_branch_o = 1'b0;
        case (opcode_i)
            OPC_BRANCH: begin
                is_branch_o = 1'b1;
                sel_o       = PC_SEL_BRANCH;
                case (func3_i)
                    F3_BEQ:  taken_o = br_eq_i;
                    F3_BNE:  taken_o = !br_eq_i;
                    F3_BLT:  taken_o = br_lt_i;
                    F3_BGE:  taken_o = !br_lt_i;
                    F3_BLTU: taken_o = br_ltu_i;
                    F3_BGEU: taken_o = !br_ltu_i;
                    default: illegal_o = 1'b1;
                endcase
            end
            OPC_JAL: begin
                taken_o = 1'b1;
                sel_o   = PC_SEL_JAL;
            end
            OPC_JALR: begin
                taken_o = 1'b1;
                sel_o   = PC_SEL_JALR;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - EX-stage branch/jump resolution: registered redirect then fixed flush
// Optional performance counters are built when BR_PERF_CNT_EN is defined.
module branch_resolve_unit
    import otter_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        stall,
    input  logic [6:0]  opcode,
    input  logic [2:0]  func3,
    input  logic        br_eq,
    input  logic        br_lt,
    input  logic        br_ltu,
    input  logic [31:0] branch_tgt,
    input  logic [31:0] jal_tgt,
    input  logic [31:0] jalr_tgt,
    output logic        redirect,
    output logic [1:0]  pc_sel,
    output logic [31:0] target_out,
    output logic        flush,
    output logic        illegal_br
`ifdef BR_PERF_CNT_EN
    ,
    output logic [31:0] taken_cnt,
    output logic [31:0] branch_cnt
`endif
);

    // Number of FLUSH-state cycles that follow the REDIRECT cycle.
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    br_state_e   state_q, state_d;
    pc_sel_e     sel_q, sel_d;
    logic [31:0] target_q, target_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        illegal_q, illegal_d;

    logic        dec_taken, dec_illegal, dec_is_branch;
    pc_sel_e     dec_sel;
    logic        sample;

    br_taken_decode u_decode (
        .opcode_i    (opcode),
        .func3_i     (func3),
        .br_eq_i     (br_eq),
        .br_lt_i     (br_lt),
        .br_ltu_i    (br_ltu),
        .taken_o     (dec_taken),
        .sel_o       (dec_sel),
        .illegal_o   (dec_illegal),
        .is_branch_o (dec_is_branch)
    );

    // Only IDLE evaluates EX; anything seen during REDIRECT/FLUSH is a shadow instruction.
    assign sample = (state_q == ST_IDLE) && ex_valid && !stall;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        target_d  = target_q;
        cnt_d     = cnt_q;
        illegal_d = sample && dec_illegal;
        case (state_q)
            ST_IDLE: begin
                if (sample && dec_taken) begin
                    state_d = ST_REDIRECT;
                    sel_d   = dec_sel;
                    case (dec_sel)
                        PC_SEL_JALR: target_d = jalr_tgt & 32'hFFFF_FFFE;
                        PC_SEL_JAL:  target_d = jal_tgt;
                        default:     target_d = branch_tgt;
                    endcase
                end
            end
            ST_REDIRECT: begin
                if (!stall) begin
                    cnt_d   = FLUSH_LOAD;
                    state_d = (FLUSH_LOAD == 3'd0) ? ST_IDLE : ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!stall) begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q <= 3'd1) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sel_q     <= PC_SEL_PC4;
            target_q  <= 32'd0;
            cnt_q     <= 3'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            target_q  <= target_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    assign redirect   = (state_q == ST_REDIRECT);
    assign flush      = (state_q != ST_IDLE);
    assign pc_sel     = (state_q == ST_REDIRECT) ? sel_q : PC_SEL_PC4;
    assign target_out = target_q;
    assign illegal_br = illegal_q;

`ifdef BR_PERF_CNT_EN
    logic [31:0] taken_cnt_q, branch_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt_q  <= 32'd0;
            branch_cnt_q <= 32'd0;
        end else begin
            if (sample && dec_is_branch) branch_cnt_q <= branch_cnt_q + 32'd1;
            if (sample && dec_taken)     taken_cnt_q  <= taken_cnt_q + 32'd1;
        end
    end

    assign taken_cnt  = taken_cnt_q;
    assign branch_cnt = branch_cnt_q;
`else
    logic unused_is_branch;
    assign unused_is_branch = dec_is_branch;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed scoreboard bench for branch_resolve_unit (FLUSH_CYCLES=2)
module tb_branch_resolve_unit;

    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_ALU  = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, stall;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic        br_eq, br_lt, br_ltu;
    logic [31:0] branch_tgt, jal_tgt, jalr_tgt;
    logic        redirect, flush, illegal_br;
    logic [1:0]  pc_sel;
    logic [31:0] target_out;
`ifdef BR_PERF_CNT_EN
    logic [31:0] taken_cnt, branch_cnt;
`endif

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       tag;
        logic        redirect;
        logic [1:0]  pc_sel;
        logic [31:0] target;
        logic        flush;
        logic        illegal;
    } exp_t;

    exp_t sb[$];

    branch_resolve_unit #(.FLUSH_CYCLES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_valid   (ex_valid),
        .stall      (stall),
        .opcode     (opcode),
        .func3      (func3),
        .br_eq      (br_eq),
        .br_lt      (br_lt),
        .br_ltu     (br_ltu),
        .branch_tgt (branch_tgt),
        .jal_tgt    (jal_tgt),
        .jalr_tgt   (jalr_tgt),
        .redirect   (redirect),
        .pc_sel     (pc_sel),
        .target_out (target_out),
        .flush      (flush),
        .illegal_br (illegal_br)
`ifdef BR_PERF_CNT_EN
        ,
        .taken_cnt  (taken_cnt),
        .branch_cnt (branch_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input string tag, input logic v, input logic s,
                        input logic [6:0] op, input logic [2:0] f3,
                        input logic eq, input logic lt, input logic ltu,
                        input logic [31:0] bt, input logic [31:0] jt, input logic [31:0] jrt,
                        input logic er, input logic [1:0] es, input logic [31:0] et,
                        input logic ef, input logic ei);
        exp_t e;
        ex_valid = v; stall = s; opcode = op; func3 = f3;
        br_eq = eq; br_lt = lt; br_ltu = ltu;
        branch_tgt = bt; jal_tgt = jt; jalr_tgt = jrt;
        e.tag = tag; e.redirect = er; e.pc_sel = es; e.target = et; e.flush = ef; e.illegal = ei;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".redirect"}, 32'(redirect), 32'(e.redirect));
        chk({e.tag, ".pc_sel"}, 32'(pc_sel), 32'(e.pc_sel));
        chk({e.tag, ".target"}, target_out, e.target);
        chk({e.tag, ".flush"}, 32'(flush), 32'(e.flush));
        chk({e.tag, ".illegal"}, 32'(illegal_br), 32'(e.illegal));
    endtask

    task automatic idle(input string tag, input logic s, input logic er, input logic [1:0] es,
                        input logic [31:0] et, input logic ef, input logic ei);
        step(tag, 1'b0, s, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, er, es, et, ef, ei);
    endtask

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; stall = 1'b0; opcode = 7'd0; func3 = 3'd0;
        br_eq = 1'b0; br_lt = 1'b0; br_ltu = 1'b0;
        branch_tgt = 32'd0; jal_tgt = 32'd0; jalr_tgt = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.redirect", 32'(redirect), 32'd0);
        chk("rst.pc_sel", 32'(pc_sel), 32'd0);
        chk("rst.target", target_out, 32'd0);
        chk("rst.flush", 32'(flush), 32'd0);
        chk("rst.illegal", 32'(illegal_br), 32'd0);
        rst_n = 1'b1;

        // BEQ taken: redirect then flush for two cycles total
        step("beq", 1, 0, OP_BR, 3'b000, 1, 0, 0, 32'h100, 32'h0, 32'h0, 1, 2'd2, 32'h100, 1, 0);
        idle("beq_fl", 0, 0, 2'd0, 32'h100, 1, 0);
        idle("beq_end", 0, 0, 2'd0, 32'h100, 0, 0);
        // BGEU with ltu=1: not taken
        step("bgeu", 1, 0, OP_BR, 3'b111, 0, 0, 1, 32'h200, 32'h0, 32'h0, 0, 2'd0, 32'h100, 0, 0);
        idle("bgeu_q", 0, 0, 2'd0, 32'h100, 0, 0);
        // JALR clears target bit 0
        step("jalr", 1, 0, OP_JALR, 3'b000, 0, 0, 0, 32'h0, 32'h0, 32'h2003, 1, 2'd1, 32'h2002, 1, 0);
        idle("jalr_fl", 0, 0, 2'd0, 32'h2002, 1, 0);
        idle("jalr_end", 0, 0, 2'd0, 32'h2002, 0, 0);
        // Taken BNE then JALs in the shadow: squashed
        step("bne", 1, 0, OP_BR, 3'b001, 0, 0, 0, 32'h300, 32'h0, 32'h0, 1, 2'd2, 32'h300, 1, 0);
        step("jal_sq1", 1, 0, OP_JAL, 3'b000, 0, 0, 0, 32'h0, 32'h400, 32'h0, 0, 2'd0, 32'h300, 1, 0);
        step("jal_sq2", 1, 0, OP_JAL, 3'b000, 0, 0, 0, 32'h0, 32'h400, 32'h0, 0, 2'd0, 32'h300, 0, 0);
        idle("post_sq", 0, 0, 2'd0, 32'h300, 0, 0);
        // BLT taken, stall 3 cycles in REDIRECT
        step("blt", 1, 0, OP_BR, 3'b100, 0, 1, 0, 32'h500, 32'h0, 32'h0, 1, 2'd2, 32'h500, 1, 0);
        for (int i = 0; i < 3; i++)
            step("stall", 1, 1, OP_BR, 3'b100, 0, 1, 0, 32'h600, 32'h0, 32'h0, 1, 2'd2, 32'h500, 1, 0);
        idle("unstall", 0, 0, 2'd0, 32'h500, 1, 0);
        idle("stall_end", 0, 0, 2'd0, 32'h500, 0, 0);
        // Illegal func3 values
        step("ill010", 1, 0, OP_BR, 3'b010, 1, 1, 1, 32'h700, 32'h0, 32'h0, 0, 2'd0, 32'h500, 0, 1);
        idle("ill010_end", 0, 0, 2'd0, 32'h500, 0, 0);
        step("ill011", 1, 0, OP_BR, 3'b011, 0, 0, 0, 32'h700, 32'h0, 32'h0, 0, 2'd0, 32'h500, 0, 1);
        idle("ill011_end", 0, 0, 2'd0, 32'h500, 0, 0);
        // Non-events
        step("bne_nt", 1, 0, OP_BR, 3'b001, 1, 0, 0, 32'h777, 32'h0, 32'h0, 0, 2'd0, 32'h500, 0, 0);
        step("alu", 1, 0, OP_ALU, 3'b000, 1, 1, 1, 32'h777, 32'h777, 32'h777, 0, 2'd0, 32'h500, 0, 0);
        step("jal_nv", 0, 0, OP_JAL, 3'b000, 0, 0, 0, 32'h0, 32'h777, 32'h0, 0, 2'd0, 32'h500, 0, 0);
        // BGE with lt=0 is taken
        step("bge", 1, 0, OP_BR, 3'b101, 0, 0, 1, 32'h800, 32'h0, 32'h0, 1, 2'd2, 32'h800, 1, 0);
        idle("bge_fl", 0, 0, 2'd0, 32'h800, 1, 0);
        idle("bge_end", 0, 0, 2'd0, 32'h800, 0, 0);
        // JAL, then reset asynchronously mid-FLUSH
        step("jal_a", 1, 0, OP_JAL, 3'b000, 0, 0, 0, 32'h0, 32'h900, 32'h0, 1, 2'd3, 32'h900, 1, 0);
        idle("jal_a_fl", 0, 0, 2'd0, 32'h900, 1, 0);
`ifdef BR_PERF_CNT_EN
        chk("perf.branch_cnt", branch_cnt, 32'd8);
        chk("perf.taken_cnt", taken_cnt, 32'd6);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.flush", 32'(flush), 32'd0);
        chk("arst.redirect", 32'(redirect), 32'd0);
        chk("arst.pc_sel", 32'(pc_sel), 32'd0);
        chk("arst.target", target_out, 32'd0);
`ifdef BR_PERF_CNT_EN
        chk("arst.taken_cnt", taken_cnt, 32'd0);
`endif
        @(posedge clk);
        #1;
        chk("arst.hold_flush", 32'(flush), 32'd0);
        rst_n = 1'b1;
        step("jal_r", 1, 0, OP_JAL, 3'b000, 0, 0, 0, 32'h0, 32'hA00, 32'h0, 1, 2'd3, 32'hA00, 1, 0);
        idle("jal_r_fl", 0, 0, 2'd0, 32'hA00, 1, 0);
        idle("jal_r_end", 0, 0, 2'd0, 32'hA00, 0, 0);
`ifdef BR_PERF_CNT_EN
        chk("perf2.branch_cnt", branch_cnt, 32'd0);
        chk("perf2.taken_cnt", taken_cnt, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
